// File: rtl/accum_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : accum_arbiter_if
// Brief    : Operand request and burst-sum result bundle for accum_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface accum_arbiter_if #(
    parameter int WIDTH_P = 8,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ*WIDTH_P-1:0] req_data_i;
    logic [NUM_REQ-1:0]         req_last_i;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic                       res_valid_o;
    logic [WIDTH_P-1:0]         res_data_o;
    logic [ID_W-1:0]            res_id_o;
    logic                       res_ready_i;
    logic                       busy_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, res_ready_i,
        output req_ready_o, res_valid_o, res_data_o, res_id_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_data_o, res_id_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/accum_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : accum_arbiter
// Brief    : Round-robin shared burst accumulator; define ACCUM_ARBITER_SAT_EN
//            for unsigned saturating accumulation instead of wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module accum_arbiter #(
    parameter int WIDTH_P = 8,
    parameter int NUM_REQ = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    accum_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH_P-1:0]   r_acc;
    logic [WIDTH_P-1:0]   r_res_data;
    logic [ID_W-1:0]      r_res_id;
    logic                 r_res_valid;
    logic [ID_W-1:0]      r_grant;
    logic [ID_W-1:0]      r_rr_ptr;

    logic [WIDTH_P-1:0]   w_ops [NUM_REQ];
    logic [WIDTH_P-1:0]   w_beat;
    logic [WIDTH_P-1:0]   w_sum;
    logic [ID_W-1:0]      w_pick;
    logic [ID_W-1:0]      w_grant_inc;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_found;
    logic                 w_xfer;
    logic                 w_last;
    int                   w_scan;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_ops[g] = bus.req_data_i[g*WIDTH_P +: WIDTH_P];
    end

    assign w_beat      = w_ops[r_grant];
    assign w_xfer      = (r_state == S_ACCUM) && bus.req_valid_i[r_grant];
    assign w_last      = bus.req_last_i[r_grant];
    assign w_grant_inc = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

`ifdef ACCUM_ARBITER_SAT_EN
    logic [WIDTH_P:0] w_sum_ext;
    assign w_sum_ext = {1'b0, r_acc} + {1'b0, w_beat};
    // Adding non-negative operands keeps an all-ones accumulator pinned there.
    assign w_sum     = w_sum_ext[WIDTH_P] ? {WIDTH_P{1'b1}} : w_sum_ext[WIDTH_P-1:0];
`else
    assign w_sum     = r_acc + w_beat;
`endif

    // First requesting index at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = int'(r_rr_ptr) + i;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            if (!w_found && bus.req_valid_i[w_scan[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_ready[r_grant] = 1'b1;
                if (w_xfer && w_last) begin
                    w_state_nxt = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.res_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_acc   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc <= w_sum;
                        if (w_last) begin
                            r_res_data  <= w_sum;
                            r_res_id    <= r_grant;
                            r_res_valid <= 1'b1;
                            r_rr_ptr    <= w_grant_inc;
                        end
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready_i) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.res_valid_o = r_res_valid;
    assign bus.res_data_o  = r_res_data;
    assign bus.res_id_o    = r_res_id;
    assign bus.busy_o      = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_accum_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_arbiter
// Brief    : Directed and randomized bench for accum_arbiter with a burst-level
//            reference model (honours ACCUM_ARBITER_SAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_arbiter;
    localparam int W    = 8;
    localparam int N    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accum_arbiter_if #(.WIDTH_P(W), .NUM_REQ(N)) bus ();

    accum_arbiter #(.WIDTH_P(W), .NUM_REQ(N)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pending operands per requester: {last, data}
    logic [W:0] pq [N][$];
    int m_phase, m_grant, m_ptr, m_total, m_res_data, m_res_id;
    int vprob     = 100;
    bit rand_mode = 1'b0;
    int bp_left   = 0;
    int hold_cnt  = 0;
    int log_id[$];
    int log_data[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int expected_sum(input int total);
`ifdef ACCUM_ARBITER_SAT_EN
        return (total > MAXV) ? MAXV : total;
`else
        return total % (MAXV + 1);
`endif
    endfunction

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (pq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int k, input int val, input bit last);
        pq[k].push_back({last, W'(val)});
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (rand_mode && pq[k].size() == 0 && $urandom_range(0, 99) < 15) begin
                int len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    int v = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255);
                    if ($urandom_range(0, 9) == 0) v = 0;
                    push(k, v, j == len - 1);
                end
            end
            if (pq[k].size() > 0 && $urandom_range(0, 99) < vprob) begin
                bus.req_valid_i[k]       = 1'b1;
                bus.req_data_i[k*W +: W] = pq[k][0][W-1:0];
                bus.req_last_i[k]        = pq[k][0][W];
            end else begin
                bus.req_valid_i[k]       = 1'b0;
                bus.req_data_i[k*W +: W] = W'($urandom);
                bus.req_last_i[k]        = 1'($urandom);
            end
        end
        if (m_phase == 2 && bp_left > 0) begin
            bus.res_ready_i = 1'b0;
            bp_left--;
        end else begin
            bus.res_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Check outputs mid-cycle, then advance the model over the coming edge.
    task automatic step();
        @(negedge clk);
        chk("busy", bus.busy_o, (m_phase != 0) ? 1 : 0);
        chk("req_ready", bus.req_ready_o, (m_phase == 1) ? (1 << m_grant) : 0);
        chk("res_valid", bus.res_valid_o, (m_phase == 2) ? 1 : 0);
        if (m_phase == 2) begin
            hold_cnt++;
            chk("res_data", bus.res_data_o, m_res_data);
            chk("res_id", bus.res_id_o, m_res_id);
        end
        case (m_phase)
            0: begin
                if (bus.req_valid_i != '0) begin
                    for (int i = 0; i < N; i++) begin
                        int c = (m_ptr + i) % N;
                        if (bus.req_valid_i[c]) begin
                            m_grant = c;
                            break;
                        end
                    end
                    m_phase = 1;
                    m_total = 0;
                end
            end
            1: begin
                if (bus.req_valid_i[m_grant]) begin
                    m_total += int'(bus.req_data_i[m_grant*W +: W]);
                    if (bus.req_last_i[m_grant]) begin
                        m_phase    = 2;
                        m_res_data = expected_sum(m_total);
                        m_res_id   = m_grant;
                        m_ptr      = (m_grant + 1) % N;
                    end
                    void'(pq[m_grant].pop_front());
                end
            end
            default: begin
                if (bus.res_ready_i) begin
                    log_id.push_back(int'(bus.res_id_o));
                    log_data.push_back(int'(bus.res_data_o));
                    m_phase = 0;
                end
            end
        endcase
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int c = 0;
        drive();
        do begin
            step();
            c++;
        end while (!(all_empty() && m_phase == 0) && c < budget);
        if (c >= budget) chk({tag, "_timeout"}, c, budget - 1);
    endtask

    task automatic clear_log();
        log_id.delete();
        log_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, bus.res_valid_o, 0);
        chk({tag, "_res_data"}, bus.res_data_o, 0);
        chk({tag, "_res_id"}, bus.res_id_o, 0);
        chk({tag, "_req_ready"}, bus.req_ready_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_phase = 0; m_grant = 0; m_ptr = 0; m_total = 0; m_res_data = 0; m_res_id = 0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        bus.res_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin: every requester eager with single-beat bursts
        clear_log();
        push(0, 10, 1); push(0, 14, 1);
        push(1, 11, 1); push(2, 12, 1); push(3, 13, 1);
        run_until_idle("rr", 100);
        chk("rr_count", log_id.size(), 5);
        for (int i = 0; i < log_id.size() && i < 5; i++) begin
            chk("rr_id", log_id[i], (i == 4) ? 0 : i);
            chk("rr_data", log_data[i], (i == 4) ? 14 : 10 + i);
        end

        // Basic multi-beat sum
        clear_log();
        push(0, 3, 0); push(0, 5, 0); push(0, 7, 1);
        run_until_idle("basic", 100);
        chk("basic_count", log_id.size(), 1);
        if (log_id.size() > 0) begin
            chk("basic_data", log_data[0], 15);
            chk("basic_id", log_id[0], 0);
        end

        // Overflow
        clear_log();
        push(1, 200, 0); push(1, 100, 1);
        run_until_idle("ovf", 100);
        chk("ovf_count", log_id.size(), 1);
        if (log_id.size() > 0) begin
`ifdef ACCUM_ARBITER_SAT_EN
            chk("ovf_data", log_data[0], 255);
`else
            chk("ovf_data", log_data[0], 44);
`endif
            chk("ovf_id", log_id[0], 1);
        end

        // Grant lock: req2 owns the accumulator while req0 waits
        clear_log();
        push(2, 1, 0); push(2, 2, 0); push(2, 3, 0); push(2, 4, 1);
        push(0, 9, 1);
        run_until_idle("lock", 100);
        chk("lock_count", log_id.size(), 2);
        if (log_id.size() == 2) begin
            chk("lock_id0", log_id[0], 2);
            chk("lock_data0", log_data[0], 10);
            chk("lock_id1", log_id[1], 0);
            chk("lock_data1", log_data[1], 9);
        end

        // Backpressure: result held for 5 stalled cycles, then accepted once
        clear_log();
        hold_cnt = 0;
        bp_left  = 5;
        push(1, 4, 0); push(1, 5, 1);
        run_until_idle("bp", 100);
        chk("bp_hold_cycles", hold_cnt, 6);
        chk("bp_count", log_id.size(), 1);
        if (log_id.size() > 0) begin
            chk("bp_data", log_data[0], 9);
            chk("bp_id", log_id[0], 1);
        end

        // Asynchronous reset mid-burst
        clear_log();
        push(0, 50, 0); push(0, 60, 0); push(0, 70, 1);
        drive();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        for (int k = 0; k < N; k++) pq[k].delete();
        m_phase = 0; m_ptr = 0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        push(3, 4, 1);
        run_until_idle("post_reset", 100);
        chk("post_reset_count", log_id.size(), 1);
        if (log_id.size() > 0) begin
            chk("post_reset_data", log_data[0], 4);
            chk("post_reset_id", log_id[0], 3);
        end

        // Randomized traffic against the model
        clear_log();
        rand_mode = 1'b1;
        vprob     = 70;
        drive();
        repeat (3000) step();
        rand_mode = 1'b0;
        vprob     = 100;
        run_until_idle("drain", 500);
        chk("rand_results_seen", (log_id.size() > 50) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
